// File: rtl/fp_mul_scheduler_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_scheduler_pkg
//  Purpose  : Shared types and constants for the FP multiplier scheduler.
//             This package holds the FSM state encoding and the
//             single-precision field layout.
//  Revision : 1.0 - initial release
// ============================================================================
package fp_mul_scheduler_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int BIAS  = 127;
   localparam int EXP_W = 8;
   localparam int MAN_W = 23;

endpackage
`default_nettype wire

// File: rtl/fp_mul_core.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_core
//  Purpose  : Combinational single-precision multiply. It truncates the
//             result, and only an exact +0 operand is treated as special.
//  Ports    : a, b    - operands (IEEE-754 single layout)
//             product - a*b, sign/exponent/truncated mantissa
//  Revision : 1.0 - initial release
// ============================================================================
module fp_mul_core
   import fp_mul_scheduler_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] product
);

   localparam int SIGN_BIT = EXP_W + MAN_W;
   localparam int PROD_W   = 2 * (MAN_W + 1);

   logic              sign;
   logic [MAN_W:0]    man_a;
   logic [MAN_W:0]    man_b;
   logic [PROD_W-1:0] prod;
   logic [EXP_W-1:0]  exp_sum;
   logic [EXP_W-1:0]  exp_res;
   logic [MAN_W-1:0]  man_res;
   logic              unused_low_bits;

   always_comb begin
      sign    = a[SIGN_BIT] ^ b[SIGN_BIT];
      man_a   = {1'b1, a[MAN_W-1:0]};
      man_b   = {1'b1, b[MAN_W-1:0]};
      prod    = {{(MAN_W+1){1'b0}}, man_a} * {{(MAN_W+1){1'b0}}, man_b};
      // The exponent is 8-bit and wraps mod 256. No over/underflow detection.
      exp_sum = a[SIGN_BIT-1:MAN_W] + b[SIGN_BIT-1:MAN_W] - EXP_W'(BIAS);
      if (prod[PROD_W-1]) begin
         man_res = prod[PROD_W-2:MAN_W+1];
         exp_res = exp_sum + EXP_W'(1);
      end else begin
         man_res = prod[PROD_W-3:MAN_W];
         exp_res = exp_sum;
      end
      product = '0;
      if ((a != '0) && (b != '0)) begin
         product = XLEN'({sign, exp_res, man_res});
      end
   end

   // The truncated low product bits are intentionally discarded.
   assign unused_low_bits = ^prod[MAN_W-1:0];

endmodule
`default_nettype wire

// File: rtl/fp_mul_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fp_mul_scheduler
//  Purpose  : Round-robin arbiter that shares one fp_mul_core among NREQ
//             requesters. A request is accepted in IDLE. The product is
//             registered in MUL, and the result is held in RESP until the
//             consumer accepts it.
//  Ports    : clk, rst            - clock, synchronous active-high reset
//             req_valid/req_ready - per-requester handshake (ready one-hot)
//             req_a, req_b        - packed operands, slice i = requester i
//             rsp_valid/rsp_ready - result handshake
//             rsp_data, rsp_id    - product and owning requester index
//  Revision : 1.0 - initial release (NREQ must be >= 2)
// ============================================================================
module fp_mul_scheduler
   import fp_mul_scheduler_pkg::*;
#(
   parameter int NREQ = 4,
   parameter int XLEN = 32
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req_valid,
   output logic [NREQ-1:0]          req_ready,
   input  logic [NREQ*XLEN-1:0]     req_a,
   input  logic [NREQ*XLEN-1:0]     req_b,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [XLEN-1:0]          rsp_data,
   output logic [$clog2(NREQ)-1:0]  rsp_id
);

   localparam int              IDW  = $clog2(NREQ);
   localparam logic [IDW-1:0]  LAST = IDW'(NREQ - 1);

   state_t          state;
   state_t          next_state;
   logic [IDW-1:0]  ptr;
   logic [IDW-1:0]  lat_id;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [XLEN-1:0] product;

   logic            win_found;
   logic [IDW-1:0]  win_idx;
   logic [XLEN-1:0] sel_a;
   logic [XLEN-1:0] sel_b;
   logic            accept;

   // Round-robin search. The first pass covers indices ptr..NREQ-1.
   // The second pass wraps around and covers 0..ptr-1.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      sel_a     = '0;
      sel_b     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && (IDW'(i) >= ptr) && req_valid[i]) begin
            win_found = 1'b1;
            win_idx   = IDW'(i);
            sel_a     = req_a[i*XLEN +: XLEN];
            sel_b     = req_b[i*XLEN +: XLEN];
         end
      end
      for (int i = 0; i < NREQ; i++) begin
         if (!win_found && (IDW'(i) < ptr) && req_valid[i]) begin
            win_found = 1'b1;
            win_idx   = IDW'(i);
            sel_a     = req_a[i*XLEN +: XLEN];
            sel_b     = req_b[i*XLEN +: XLEN];
         end
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // FSM next-state logic and handshake outputs. Reset masks the grant
   // in the same cycle, so no operand is accepted while rst is high.
   always_comb begin
      next_state = state;
      req_ready  = '0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (win_found && !rst) begin
               req_ready  = NREQ'(1) << win_idx;
               accept     = 1'b1;
               next_state = MUL;
            end
         end
         MUL: begin
            next_state = RESP;
         end
         RESP: begin
            if (rsp_ready) begin
               next_state = IDLE;
            end
         end
         default: begin
            next_state = IDLE;
         end
      endcase
   end

   // Operand latch, priority pointer and response registers
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr       <= '0;
         lat_id    <= '0;
         op_a      <= '0;
         op_b      <= '0;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_id    <= '0;
      end else begin
         if (accept) begin
            op_a   <= sel_a;
            op_b   <= sel_b;
            lat_id <= win_idx;
            ptr    <= (win_idx == LAST) ? '0 : win_idx + IDW'(1);
         end
         if (state == MUL) begin
            rsp_data  <= product;
            rsp_id    <= lat_id;
            rsp_valid <= 1'b1;
         end
         if ((state == RESP) && rsp_ready) begin
            rsp_valid <= 1'b0;
         end
      end
   end

   fp_mul_core #(
      .XLEN (XLEN)
   ) u_core (
      .a       (op_a),
      .b       (op_b),
      .product (product)
   );

endmodule
`default_nettype wire

// File: doc/fp_mul_scheduler.md
FP_MUL_SCHEDULER -- requirements
Module: fp_mul_scheduler

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one multiplier.
REQ-002 SHALL have parameter XLEN, default 32: operand/result width (IEEE-754 single layout).
REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port req_valid, input, NREQ: per-requester operand-pair valid.
REQ-006 SHALL have port req_ready, output, NREQ: per-requester accept, at most one bit set (one-hot).
REQ-007 SHALL have port req_a, input, NREQ*XLEN: packed operand A, slice i belongs to requester i.
REQ-008 SHALL have port req_b, input, NREQ*XLEN: packed operand B, slice i belongs to requester i.
REQ-009 SHALL have port rsp_valid, output, 1: result available.
REQ-010 SHALL have port rsp_ready, input, 1: result consumer accept.
REQ-011 SHALL have port rsp_data, output, XLEN: product.
REQ-012 SHALL have port rsp_id, output, clog2(NREQ): index of the requester that owns rsp_data.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, RESP.
REQ-014 IDLE: if any req_valid bit is set, SHALL combinationally assert req_ready for the round-robin winner, latch its operands and index, and go to MUL; otherwise stay in IDLE.
REQ-015 Round-robin: search starts at priority pointer ptr; on acceptance ptr SHALL become (winner+1) mod NREQ.
REQ-016 MUL: SHALL register the core result into rsp_data and the latched index into rsp_id, set rsp_valid, and go to RESP (one cycle).
REQ-017 RESP: SHALL hold rsp_valid, rsp_data and rsp_id stable until rsp_valid&&rsp_ready, then clear rsp_valid and go to IDLE.
REQ-018 req_ready SHALL be all-zero in MUL and RESP; no new request is accepted while a result is pending.
REQ-019 Latency SHALL be: accept at cycle T, rsp_valid first high at T+2; peak throughput is one product per 3 cycles.
REQ-020 Multiply rules: sign = sA xor sB; 24x24 mantissa product with hidden 1; exponent = eA+eB-127 (8-bit, wraps mod 256).
REQ-021 Normalization: if product bit 47 is set, mantissa = bits 46:24 and exponent +1; otherwise mantissa = bits 45:23.
REQ-022 Rounding: the mantissa SHALL be truncated; no rounding is applied.
REQ-023 If either operand equals 32'h0000_0000, the result SHALL be 32'h0000_0000; -0, denormal, Inf and NaN inputs SHALL get no special handling.
REQ-024 A requester dropping req_valid before grant SHALL be skipped with no side effect; req_valid in MUL/RESP is ignored, not queued.

Reset
REQ-025 On rst: state=IDLE, ptr=0, rsp_valid=0, rsp_data=0, rsp_id=0, req_ready=0 in the same cycle.
REQ-026 Reset asserted in MUL or RESP SHALL discard the in-flight operation; no response is ever issued for it.

Structure
REQ-027 Shared package SHALL hold the FSM state enum, BIAS=127, and the field widths EXP_W=8, MAN_W=23.
REQ-028 SHALL instantiate one combinational sub-module fp_mul_core (a, b -> product per REQ-020..023); fp_mul_scheduler holds all sequential logic.

Verification
REQ-029 Req0: 0x40000000 x 0x40400000 (2.0x3.0) -> rsp_data=0x40C00000, rsp_id=0, rsp_valid high exactly 2 cycles after accept.
REQ-030 Req2: 0x3FC00000 x 0x3FC00000 (1.5x1.5, normalization path) -> 0x40100000; 0xC0000000 x 0x40400000 -> 0xC0C00000.
REQ-031 Zero operand: 0x00000000 x 0x40400000 -> 0x00000000.
REQ-032 All four req_valid held high from reset, rsp_ready=1 -> grants in order 0,1,2,3,0, each grant 3 cycles apart, req_ready one-hot.
REQ-033 rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, req_ready=0 throughout; the response completes on the first cycle with rsp_ready=1.
REQ-034 rst pulsed while in MUL -> next cycle rsp_valid=0 and state IDLE; the next accepted request goes to requester 0 (ptr=0).
